mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter and sequencer between the core's requesters (port 0: instruction fetch, port 1: load/store) and the single external memory port of `mem_controller`. It arbitrates round-robin, registers the winning request, and drives one memory access at a time. It waits a fixed read latency and then returns read data or a write acknowledge to the granted port. It sits between the pipeline front/back ends and `mem_controller`, and replaces the direct single-requester connection.

## Interface
- `DATA_WIDTH`, default `DATA_WIDTH` from define.v: address and data width.
- `READ_LATENCY`, default 1: cycles from the `mem_r_en` cycle to valid `mem_r_data`. Must be ≥1.
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `p0_req`, `p1_req`  in  1  access request, level
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read
- `p0_addr`, `p1_addr`  in  DATA_WIDTH  access address
- `p0_wdata`, `p1_wdata`  in  DATA_WIDTH  write data
- `p0_gnt`, `p1_gnt`  out  1  one-cycle pulse; request accepted
- `p0_rsp`, `p1_rsp`  out  1  one-cycle pulse; read data valid or write done
- `rsp_data`  out  DATA_WIDTH  read data, shared; valid only with a `pX_rsp` pulse of a read
- `busy`  out  1  high in every state except IDLE
- `mem_addr`, `mem_w_data`  out  DATA_WIDTH  to `mem_controller` `i_address` / `i_data`
- `mem_r_en`, `mem_w_en`  out  1  to `mem_controller` `i_ren` / `i_wen`
- `mem_r_data`  in  DATA_WIDTH  from `mem_controller` `o_data`

## Operation
- States are IDLE, ISSUE, WAIT and RESP. Reset enters IDLE.
- Arbitration is evaluated only in IDLE and RESP, on the registered view of `pX_req`.
  - If one port requests, it wins.
  - If both request, the port not in `last_gnt` wins.
  - `last_gnt` resets to 1, so port 0 wins the first tie.
- On a win:
  - latch that port's `we`, `addr` and `wdata` into `mem_addr`, `mem_w_data` and `op_we`;
  - record `sel`;
  - update `last_gnt`;
  - pulse `pX_gnt`;
  - go to ISSUE.
- If there is no request: RESP goes to IDLE, and IDLE stays in IDLE.
- ISSUE lasts one cycle. `mem_r_en = !op_we` and `mem_w_en = op_we`.
  - Write: go to RESP.
  - Read: load `cnt = READ_LATENCY-1`, then go to RESP if `cnt` is 0, otherwise go to WAIT.
- WAIT decrements `cnt` and goes to RESP on the cycle `cnt` reaches 0. Both memory enables are 0.
- Transition into RESP:
  - for a read, capture `mem_r_data` into `rsp_data` on that edge;
  - in the RESP cycle, `p[sel]_rsp` = 1.
- `mem_addr` and `mem_w_data` change only on a grant edge. They stay stable through ISSUE, WAIT and RESP.
- Requester rule: hold `req`, `we`, `addr` and `wdata` stable until `gnt`. After `gnt`, drop or change them freely.
  - Dropping `req` before `gnt` withdraws the request.
  - `req` still high after `gnt` is a new request.
- `cnt` width is `$clog2(READ_LATENCY+1)`, with no wrap.
- `rsp_data` keeps its old value on writes.
- Reset in mid-access: everything returns to IDLE. The in-flight access gets no `rsp` and no further memory enable.

## Timing
- Reset values:
  - `pX_gnt`, `pX_rsp`, `mem_r_en`, `mem_w_en`, `busy`: 0;
  - `mem_addr`, `mem_w_data`, `rsp_data`: 0;
  - `last_gnt`: 1.
- All outputs are registered, or decoded from registered state only. There is no input-to-output combinational path.
- Request first sampled at edge E0, with `gnt` in cycle 1 (ISSUE).
  - Write: `rsp` in cycle 2.
  - Read: `rsp` in cycle 2+READ_LATENCY-1+... precisely, `rsp` in cycle `READ_LATENCY+1` after E0.
- Back-to-back: a grant in RESP leads to ISSUE in the next cycle with no idle bubble. Peak write throughput is one access per 2 cycles.
- Simultaneous requests alternate strictly, so neither port waits more than one access.

## Structure
- Shared package holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - port index constants (`PORT_IF=0`, `PORT_LS=1`).
- One natural sub-module is `rr_arbiter2`: a 2-way round-robin picker.
  - Inputs: `req[1:0]`, `last_gnt`.
  - Outputs: one-hot `pick[1:0]`, `any`.
  - Purely combinational.
- The FSM, latency counter and latch registers stay in `mem_arbiter`.

## Test plan
- Reset: assert `rst` mid-WAIT with READ_LATENCY=3. Required response: all outputs 0 at once, no `rsp`, and `mem_r_en` never re-asserts.
- Single read: `p0_req`, `p0_we=0`, `p0_addr=0x0010`; the memory model returns `0xBEEF` after READ_LATENCY=2. Required response: `p0_gnt` at cycle 1, `mem_r_en` at cycle 1 with `mem_addr=0x0010`, `p0_rsp` at cycle 3 with `rsp_data=0xBEEF`, `busy` 0 at cycle 4.
- Single write: `p1_req`, `p1_we=1`, `addr=0x0020`, `wdata=0x1234`. Required response: `mem_w_en` one cycle with those values, and `p1_rsp` one cycle later; `rsp_data` is unchanged.
- Tie: both ports hold `req` for 4 accesses. Required response: grant order 0,1,0,1, and each `rsp` goes only to the matching port.
- Back-to-back: `p0` writes continuously. Required response: `mem_w_en` every second cycle, and `busy` never drops.
- Withdrawal: `p1_req` is pulsed while `p0` is mid-read and dropped before arbitration. Required response: no `p1_gnt` and no memory access for p1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  localparam int PORT_IF = 0;
  localparam int PORT_LS = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side bundle of the arbiter
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  p0_req;
  logic                  p0_we;
  logic [DATA_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic                  p0_rsp;

  logic                  p1_req;
  logic                  p1_we;
  logic [DATA_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic                  p1_rsp;

  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  busy;

  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_w_data;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic [DATA_WIDTH-1:0] mem_r_data;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_r_data,
    output p0_gnt, p0_rsp, p1_gnt, p1_rsp,
    output rsp_data, busy,
    output mem_addr, mem_w_data, mem_r_en, mem_w_en
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_r_data,
    input  p0_gnt, p0_rsp, p1_gnt, p1_rsp,
    input  rsp_data, busy,
    input  mem_addr, mem_w_data, mem_r_en, mem_w_en
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rtl/mem_arbiter_rr_arbiter2.sv - two-way round-robin picker
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] pick,
  output logic       any
);

  // A lone requester wins; on a tie the port that did not win last time goes
  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last_gnt ? 2'b01 : 2'b10;
    end
    any = |req;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter and single-access sequencer for the memory port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int            CW       = $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            req;
  logic [1:0]            pick;
  logic                  any;
  logic                  win;
  logic                  capture;
  logic                  sel_q;
  logic                  last_gnt_q;
  logic                  op_we_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_w_data_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [1:0]            gnt_q;
  logic [1:0]            rsp;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic                  busy;

  assign req = {bus.p1_req, bus.p0_req};

  rr_arbiter2 u_rr (
    .req      (req),
    .last_gnt (last_gnt_q),
    .pick     (pick),
    .any      (any)
  );

  // State and latency counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: arbitrate in IDLE/RESP, one ISSUE cycle, count out the read latency
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win     = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (any) begin
          win     = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (op_we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = (CNT_LOAD == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (cnt_q <= CNT_ONE) begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is taken on the edge that enters RESP
  assign capture = ((state_q == ISSUE) || (state_q == WAIT)) && (state_d == RESP) && !op_we_q;

  // Grant-edge latches for the winning request, plus read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q        <= 1'b0;
      last_gnt_q   <= 1'b1;
      op_we_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
      rsp_data_q   <= '0;
      gnt_q        <= 2'b00;
    end else begin
      gnt_q <= 2'b00;
      if (win) begin
        sel_q      <= pick[PORT_LS];
        last_gnt_q <= pick[PORT_LS];
        gnt_q      <= pick;
        if (pick[PORT_LS]) begin
          op_we_q      <= bus.p1_we;
          mem_addr_q   <= bus.p1_addr;
          mem_w_data_q <= bus.p1_wdata;
        end else begin
          op_we_q      <= bus.p0_we;
          mem_addr_q   <= bus.p0_addr;
          mem_w_data_q <= bus.p0_wdata;
        end
      end
      if (capture) begin
        rsp_data_q <= bus.mem_r_data;
      end
    end
  end

  // Outputs decoded from the registered state only
  always_comb begin
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    rsp      = 2'b00;
    busy     = (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        mem_r_en = !op_we_q;
        mem_w_en = op_we_q;
      end
      RESP:    rsp[sel_q] = 1'b1;
      default: ;
    endcase
  end

  assign bus.p0_gnt     = gnt_q[PORT_IF];
  assign bus.p1_gnt     = gnt_q[PORT_LS];
  assign bus.p0_rsp     = rsp[PORT_IF];
  assign bus.p1_rsp     = rsp[PORT_LS];
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = busy;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_w_data = mem_w_data_q;
  assign bus.mem_r_en   = mem_r_en;
  assign bus.mem_w_en   = mem_w_en;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(DW)) bus_a ();
  mem_arbiter_if #(.DATA_WIDTH(DW)) bus_b ();

  mem_arbiter #(.DATA_WIDTH(DW), .READ_LATENCY(2)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  mem_arbiter #(.DATA_WIDTH(DW), .READ_LATENCY(3)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  function automatic logic [DW-1:0] mem_model(input logic [DW-1:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5A5);
  endfunction

  logic [DW-1:0] rd_addr_a = '0;
  logic [DW-1:0] rd_addr_b = '0;

  always @(posedge clk) if (bus_a.mem_r_en) rd_addr_a <= bus_a.mem_addr;
  always @(posedge clk) if (bus_b.mem_r_en) rd_addr_b <= bus_b.mem_addr;

  assign bus_a.mem_r_data = mem_model(rd_addr_a);
  assign bus_b.mem_r_data = mem_model(rd_addr_b);

  function automatic logic [6:0] ctl_a();
    return {bus_a.p0_gnt, bus_a.p1_gnt, bus_a.p0_rsp, bus_a.p1_rsp,
            bus_a.mem_r_en, bus_a.mem_w_en, bus_a.busy};
  endfunction

  function automatic logic [6:0] ctl_b();
    return {bus_b.p0_gnt, bus_b.p1_gnt, bus_b.p0_rsp, bus_b.p1_rsp,
            bus_b.mem_r_en, bus_b.mem_w_en, bus_b.busy};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.p0_req = 0; bus_a.p0_we = 0; bus_a.p0_addr = '0; bus_a.p0_wdata = '0;
    bus_a.p1_req = 0; bus_a.p1_we = 0; bus_a.p1_addr = '0; bus_a.p1_wdata = '0;
    bus_b.p0_req = 0; bus_b.p0_we = 0; bus_b.p0_addr = '0; bus_b.p0_wdata = '0;
    bus_b.p1_req = 0; bus_b.p1_we = 0; bus_b.p1_addr = '0; bus_b.p1_wdata = '0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    idle_inputs();
    step();
    step();
    checks++;
    if (ctl_a() !== 7'b0) begin
      errors++; $display("FAIL reset_ctl got %b exp %b", ctl_a(), 7'b0);
    end
    checks++;
    if ({bus_a.mem_addr, bus_a.mem_w_data, bus_a.rsp_data} !== 48'h0) begin
      errors++; $display("FAIL reset_data got %h exp %h",
                         {bus_a.mem_addr, bus_a.mem_w_data, bus_a.rsp_data}, 48'h0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    step();
    checks++;
    if (ctl_a() !== 7'b0) begin
      errors++; $display("FAIL post_reset_idle got %b exp %b", ctl_a(), 7'b0);
    end
  endtask

  // Straight after reset: both ports request writes, port 0 must win the first tie
  task automatic test_tie();
    int p;
    bus_a.p0_we = 1; bus_a.p0_addr = 16'h0100; bus_a.p0_wdata = 16'h1111;
    bus_a.p1_we = 1; bus_a.p1_addr = 16'h0200; bus_a.p1_wdata = 16'h2222;
    bus_a.p0_req = 1; bus_a.p1_req = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i % 2 == 1) begin
        p = ((i - 1) / 2) % 2;
        checks++;
        if ({bus_a.p1_gnt, bus_a.p0_gnt} !== (p == 1 ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL tie_gnt cycle %0d got %b exp port %0d",
                             i, {bus_a.p1_gnt, bus_a.p0_gnt}, p);
        end
        checks++;
        if (bus_a.mem_addr !== (p == 1 ? 16'h0200 : 16'h0100) || bus_a.mem_w_en !== 1'b1) begin
          errors++; $display("FAIL tie_access cycle %0d got addr %h wen %b exp addr %h wen 1",
                             i, bus_a.mem_addr, bus_a.mem_w_en, (p == 1 ? 16'h0200 : 16'h0100));
        end
        if (i == 7) begin
          bus_a.p0_req = 0; bus_a.p1_req = 0;
        end
      end else begin
        p = ((i - 2) / 2) % 2;
        checks++;
        if ({bus_a.p1_rsp, bus_a.p0_rsp} !== (p == 1 ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL tie_rsp cycle %0d got %b exp port %0d",
                             i, {bus_a.p1_rsp, bus_a.p0_rsp}, p);
        end
      end
    end
    step();
    checks++;
    if (ctl_a() !== 7'b0) begin
      errors++; $display("FAIL tie_end_idle got %b exp %b", ctl_a(), 7'b0);
    end
  endtask

  task automatic test_single_read();
    bus_a.p0_req = 1; bus_a.p0_we = 0; bus_a.p0_addr = 16'h0010;
    step();
    checks++;
    if (bus_a.p0_gnt !== 1'b1 || bus_a.mem_r_en !== 1'b1 || bus_a.mem_w_en !== 1'b0 ||
        bus_a.mem_addr !== 16'h0010) begin
      errors++; $display("FAIL read_issue got gnt %b ren %b wen %b addr %h exp 1 1 0 0010",
                         bus_a.p0_gnt, bus_a.mem_r_en, bus_a.mem_w_en, bus_a.mem_addr);
    end
    bus_a.p0_req = 0;
    step();
    checks++;
    if (ctl_a() !== 7'b0000001) begin
      errors++; $display("FAIL read_wait got %b exp %b", ctl_a(), 7'b0000001);
    end
    step();
    checks++;
    if (bus_a.p0_rsp !== 1'b1 || bus_a.p1_rsp !== 1'b0 || bus_a.rsp_data !== 16'hBEEF) begin
      errors++; $display("FAIL read_rsp got rsp %b%b data %h exp 10 BEEF",
                         bus_a.p0_rsp, bus_a.p1_rsp, bus_a.rsp_data);
    end
    step();
    checks++;
    if (bus_a.busy !== 1'b0) begin
      errors++; $display("FAIL read_done_busy got %b exp 0", bus_a.busy);
    end
  endtask

  task automatic test_single_write();
    bus_a.p1_req = 1; bus_a.p1_we = 1; bus_a.p1_addr = 16'h0020; bus_a.p1_wdata = 16'h1234;
    step();
    checks++;
    if (bus_a.p1_gnt !== 1'b1 || bus_a.mem_w_en !== 1'b1 || bus_a.mem_r_en !== 1'b0 ||
        bus_a.mem_addr !== 16'h0020 || bus_a.mem_w_data !== 16'h1234) begin
      errors++; $display("FAIL write_issue got gnt %b wen %b ren %b addr %h wdata %h exp 1 1 0 0020 1234",
                         bus_a.p1_gnt, bus_a.mem_w_en, bus_a.mem_r_en, bus_a.mem_addr, bus_a.mem_w_data);
    end
    bus_a.p1_req = 0;
    step();
    checks++;
    if (bus_a.p1_rsp !== 1'b1 || bus_a.p0_rsp !== 1'b0 || bus_a.mem_w_en !== 1'b0 ||
        bus_a.rsp_data !== 16'hBEEF) begin
      errors++; $display("FAIL write_rsp got rsp1 %b rsp0 %b wen %b data %h exp 1 0 0 BEEF",
                         bus_a.p1_rsp, bus_a.p0_rsp, bus_a.mem_w_en, bus_a.rsp_data);
    end
    step();
    checks++;
    if (ctl_a() !== 7'b0) begin
      errors++; $display("FAIL write_done got %b exp %b", ctl_a(), 7'b0);
    end
  endtask

  // p0 writes continuously, changing its address after every grant
  task automatic test_back_to_back();
    logic [DW-1:0] exp_addr;
    bus_a.p0_req = 1; bus_a.p0_we = 1; bus_a.p0_addr = 16'h0300; bus_a.p0_wdata = 16'h5A5A;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (bus_a.busy !== 1'b1 || bus_a.mem_w_en !== (i % 2 == 1)) begin
        errors++; $display("FAIL b2b_cycle %0d got busy %b wen %b exp busy 1 wen %0d",
                           i, bus_a.busy, bus_a.mem_w_en, (i % 2 == 1));
      end
      if (i % 2 == 1) begin
        exp_addr = (i == 1) ? 16'h0300 : 16'h0300 + 16'(i - 2);
        checks++;
        if (bus_a.mem_addr !== exp_addr) begin
          errors++; $display("FAIL b2b_addr cycle %0d got %h exp %h", i, bus_a.mem_addr, exp_addr);
        end
        bus_a.p0_addr = 16'h0300 + 16'(i);
        if (i == 7) bus_a.p0_req = 0;
      end
    end
    step();
    checks++;
    if (bus_a.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_end_busy got %b exp 0", bus_a.busy);
    end
  endtask

  task automatic test_withdrawal();
    bus_a.p0_req = 1; bus_a.p0_we = 0; bus_a.p0_addr = 16'h0040;
    step();
    checks++;
    if (bus_a.p0_gnt !== 1'b1 || bus_a.mem_r_en !== 1'b1) begin
      errors++; $display("FAIL wd_p0_issue got gnt %b ren %b exp 1 1", bus_a.p0_gnt, bus_a.mem_r_en);
    end
    bus_a.p0_req = 0;
    bus_a.p1_req = 1; bus_a.p1_we = 1; bus_a.p1_addr = 16'h0050; bus_a.p1_wdata = 16'h7777;
    step();
    bus_a.p1_req = 0;
    for (int i = 2; i <= 6; i++) begin
      if (i > 2) step();
      checks++;
      if (bus_a.p1_gnt !== 1'b0 || bus_a.p1_rsp !== 1'b0 || bus_a.mem_r_en !== 1'b0 ||
          bus_a.mem_w_en !== 1'b0 || bus_a.mem_addr !== 16'h0040) begin
        errors++; $display("FAIL wd_no_p1 cycle %0d got gnt1 %b rsp1 %b ren %b wen %b addr %h exp 0 0 0 0 0040",
                           i, bus_a.p1_gnt, bus_a.p1_rsp, bus_a.mem_r_en, bus_a.mem_w_en, bus_a.mem_addr);
      end
      if (i == 3) begin
        checks++;
        if (bus_a.p0_rsp !== 1'b1 || bus_a.rsp_data !== 16'hA5E5) begin
          errors++; $display("FAIL wd_p0_rsp got rsp %b data %h exp 1 A5E5", bus_a.p0_rsp, bus_a.rsp_data);
        end
      end
    end
  endtask

  // READ_LATENCY=3 instance: reset lands in the middle of WAIT
  task automatic test_reset_mid_wait();
    bus_b.p0_req = 1; bus_b.p0_we = 0; bus_b.p0_addr = 16'h0060;
    step();
    checks++;
    if (bus_b.mem_r_en !== 1'b1 || bus_b.p0_gnt !== 1'b1) begin
      errors++; $display("FAIL rw_issue got ren %b gnt %b exp 1 1", bus_b.mem_r_en, bus_b.p0_gnt);
    end
    bus_b.p0_req = 0;
    step();
    checks++;
    if (ctl_b() !== 7'b0000001) begin
      errors++; $display("FAIL rw_wait got %b exp %b", ctl_b(), 7'b0000001);
    end
    #1 rst_b = 1'b1;
    #1;
    checks++;
    if (ctl_b() !== 7'b0 || bus_b.mem_addr !== '0 || bus_b.rsp_data !== '0) begin
      errors++; $display("FAIL rw_async_reset got ctl %b addr %h data %h exp 0 0 0",
                         ctl_b(), bus_b.mem_addr, bus_b.rsp_data);
    end
    step();
    rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (ctl_b() !== 7'b0) begin
        errors++; $display("FAIL rw_after_reset cycle %0d got %b exp %b", i, ctl_b(), 7'b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_withdrawal();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
